// File: rtl/sr04_pkg.sv
// Shared types and constants for the SR04 measurement scheduler.
package sr04_pkg;

    localparam int unsigned SR04_DIST_W        = 9;
    localparam int unsigned CYCLE_US_DEFAULT   = 60000;
    localparam int unsigned TIMEOUT_US_DEFAULT = 30000;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef logic [SR04_DIST_W-1:0] dist_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_DONE,
        ST_UPDATE,
        ST_SEND,
        ST_ACK,
        ST_DONE_WAIT
    } sr04_state_t;

endpackage

// File: rtl/sr04_bin2ascii.sv
// Combinational 9-bit binary to three ASCII decimal digits (hundreds, tens, ones).
module sr04_bin2ascii
    import sr04_pkg::*;
(
    input  logic [SR04_DIST_W-1:0] bin,
    output logic [7:0]             asc_hundreds,
    output logic [7:0]             asc_tens,
    output logic [7:0]             asc_ones
);

    localparam dist_t C100 = dist_t'(100);
    localparam dist_t C10  = dist_t'(10);

    always_comb begin
        asc_hundreds = 8'(dist_t'(ASCII_0) + bin / C100);
        asc_tens     = 8'(dist_t'(ASCII_0) + (bin / C10) % C10);
        asc_ones     = 8'(dist_t'(ASCII_0) + bin % C10);
    end

endmodule

// File: rtl/sr04_measure_scheduler.sv
// Trigger sequencer for the SR04 unit: holdoff, timeout, moving average and
// ASCII "DDD\r\n" streaming of each averaged distance to the UART.
module sr04_measure_scheduler
    import sr04_pkg::*;
#(
    parameter int unsigned CYCLE_US       = CYCLE_US_DEFAULT,
    parameter int unsigned TIMEOUT_US     = TIMEOUT_US_DEFAULT,
    parameter int unsigned AVG_DEPTH_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_1us,
    input  logic                   mode_auto,
    input  logic                   single_req,
    output logic                   sr_start,
    input  logic                   sr_done,
    input  logic [SR04_DIST_W-1:0] sr_distance,
    input  logic                   uart_tx_busy,
    output logic                   uart_tx_start,
    output logic [7:0]             uart_tx_data,
    output logic [SR04_DIST_W-1:0] avg_distance,
    output logic                   avg_valid,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int unsigned DEPTH = 1 << AVG_DEPTH_LOG2;
    localparam int unsigned SUM_W = SR04_DIST_W + AVG_DEPTH_LOG2;
    localparam logic [15:0] CYCLE_LIM   = 16'(CYCLE_US);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_US);

    sr04_state_t      state;
    logic [15:0]      period_cnt;
    logic [15:0]      to_cnt;
    logic             pending;
    logic [2:0]       byte_idx;
    dist_t            sample_lat;
    dist_t            sample_buf [DEPTH];
    dist_t            next_buf   [DEPTH];
    logic [SUM_W-1:0] next_sum;
    logic [7:0]       asc_h, asc_t, asc_o;
    logic [7:0]       tx_byte;
    logic             want_meas;

    sr04_bin2ascii u_bin2ascii (
        .bin          (avg_distance),
        .asc_hundreds (asc_h),
        .asc_tens     (asc_t),
        .asc_ones     (asc_o)
    );

    // Auto mode requests directly rather than through the latch, so dropping
    // mode_auto mid-sequence leaves no stale request behind.
    assign want_meas = pending | mode_auto;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        next_buf[0] = sample_lat;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            next_buf[i] = avg_valid ? sample_buf[i-1] : sample_lat;
        end
        next_sum = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            next_sum = next_sum + SUM_W'(next_buf[i]);
        end
    end

    always_comb begin
        case (byte_idx)
            3'd0:    tx_byte = asc_h;
            3'd1:    tx_byte = asc_t;
            3'd2:    tx_byte = asc_o;
            3'd3:    tx_byte = ASCII_CR;
            default: tx_byte = ASCII_LF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            period_cnt    <= CYCLE_LIM;
            to_cnt        <= '0;
            pending       <= 1'b0;
            byte_idx      <= '0;
            sample_lat    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sample_buf[i] <= '0;
            end
            sr_start      <= 1'b0;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
            avg_distance  <= '0;
            avg_valid     <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            if (tick_1us && period_cnt < CYCLE_LIM) begin
                period_cnt <= period_cnt + 16'd1;
            end
            if (single_req) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (want_meas && period_cnt >= CYCLE_LIM) begin
                        sr_start <= 1'b1;
                        state    <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    sr_start   <= 1'b0;
                    period_cnt <= '0;
                    to_cnt     <= '0;
                    pending    <= single_req;
                    state      <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (sr_done) begin
                        sample_lat <= sr_distance;
                        state      <= ST_UPDATE;
                    end else if (to_cnt == TIMEOUT_LIM) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (tick_1us) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ST_UPDATE: begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        sample_buf[i] <= next_buf[i];
                    end
                    avg_distance <= dist_t'(next_sum >> AVG_DEPTH_LOG2);
                    avg_valid    <= 1'b1;
                    timeout_err  <= 1'b0;
                    byte_idx     <= '0;
                    state        <= ST_SEND;
                end
                ST_SEND: begin
                    if (!uart_tx_busy) begin
                        uart_tx_data  <= tx_byte;
                        uart_tx_start <= 1'b1;
                        state         <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    uart_tx_start <= 1'b0;
                    if (uart_tx_busy) begin
                        state <= ST_DONE_WAIT;
                    end
                end
                ST_DONE_WAIT: begin
                    if (!uart_tx_busy) begin
                        if (byte_idx < 3'd4) begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= ST_SEND;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr04_measure_scheduler.sv
// Scoreboard bench for sr04_measure_scheduler with scaled microsecond parameters.
module tb_sr04_measure_scheduler;

    localparam int unsigned CYC = 600;
    localparam int unsigned TMO = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1us = 1'b0;
    logic       mode_auto = 1'b0;
    logic       single_req = 1'b0;
    logic       sr_done = 1'b0;
    logic [8:0] sr_distance = '0;
    logic       uart_tx_busy = 1'b0;
    logic       sr_start;
    logic       uart_tx_start;
    logic [7:0] uart_tx_data;
    logic [8:0] avg_distance;
    logic       avg_valid;
    logic       timeout_err;
    logic       busy;

    sr04_measure_scheduler #(
        .CYCLE_US       (CYC),
        .TIMEOUT_US     (TMO),
        .AVG_DEPTH_LOG2 (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_1us      (tick_1us),
        .mode_auto     (mode_auto),
        .single_req    (single_req),
        .sr_start      (sr_start),
        .sr_done       (sr_done),
        .sr_distance   (sr_distance),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .avg_distance  (avg_distance),
        .avg_valid     (avg_valid),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick_1us = 1'b1;
            @(negedge clk);
            tick_1us = 1'b0;
        end
    end

    int us_time = 0;
    always @(posedge clk) if (tick_1us) us_time <= us_time + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    int         exp_avg[$];
    int         exp_gap[$];
    int         sens_delay[$];
    int         sens_dist[$];

    int sr_starts = 0;
    int uart_starts = 0;
    int last_start_us = 0;
    int uart_busy_len = 10;
    int byte_cnt = 0;
    int stray_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input string got, input string want);
        checks++;
        errors++;
        $display("FAIL %s: got %s expected %s", name, got, want);
    endtask

    task automatic push_msg(input int avg, input string s);
        exp_avg.push_back(avg);
        for (int i = 0; i < 3; i++) exp_bytes.push_back(s[i]);
        exp_bytes.push_back(8'h0D);
        exp_bytes.push_back(8'h0A);
    endtask

    // Sensor model: answers each sr_start from the queued responses (delay < 0 = silent).
    initial begin
        int dly;
        int dst;
        int stray_served;
        stray_served = 0;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_served) begin
                stray_served = stray_cnt;
                sr_distance = 9'd300;
                sr_done = 1'b1;
                @(negedge clk);
                sr_done = 1'b0;
            end else if (rst_n && sr_start && sens_delay.size() > 0) begin
                dly = sens_delay.pop_front();
                dst = sens_dist.pop_front();
                if (dly >= 0) begin
                    repeat (dly * 4) @(negedge clk);
                    sr_distance = 9'(dst);
                    sr_done = 1'b1;
                    @(negedge clk);
                    sr_done = 1'b0;
                end
            end
        end
    end

    // sr_start monitor: checks spacing in microseconds and pulse width.
    initial begin
        int g;
        forever begin
            @(negedge clk);
            if (rst_n && sr_start) begin
                sr_starts++;
                if (exp_gap.size() == 0) begin
                    fail_evt("sr_start", "unexpected pulse", "none");
                end else begin
                    g = exp_gap.pop_front();
                    if (g >= 0) chk("sr_start_gap_us", us_time - last_start_us, g);
                end
                @(posedge clk);
                #1 last_start_us = us_time;
                @(negedge clk);
                chk("sr_start_width", sr_start, 0);
            end
        end
    end

    // UART model and byte monitor.
    initial begin
        logic [7:0] d;
        bit         bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx_start) begin
                uart_starts++;
                chk("uart_start_busy_low", uart_tx_busy, 0);
                d = uart_tx_data;
                if (byte_cnt == 0) begin
                    if (exp_avg.size() == 0) fail_evt("avg_distance", "unexpected message", "none");
                    else chk("avg_distance", avg_distance, exp_avg.pop_front());
                    chk("avg_valid", avg_valid, 1);
                    chk("timeout_err_clear", timeout_err, 0);
                end
                if (exp_bytes.size() == 0) fail_evt("uart_byte", "unexpected byte", "none");
                else chk("uart_byte", d, exp_bytes.pop_front());
                byte_cnt = (byte_cnt == 4) ? 0 : byte_cnt + 1;
                @(negedge clk);
                chk("uart_start_width", uart_tx_start, 0);
                uart_tx_busy = 1'b1;
                bad = 1'b0;
                aborted = 1'b0;
                repeat (uart_busy_len) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else if (!aborted && uart_tx_data != d) bad = 1'b1;
                end
                uart_tx_busy = 1'b0;
                if (aborted) byte_cnt = 0;
                else chk("uart_data_stable", bad, 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        mode_auto = 1'b0;
        single_req = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", int'({sr_start, uart_tx_start, uart_tx_data, avg_distance,
                                      avg_valid, timeout_err, busy}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        single_req = 1'b1;
        @(negedge clk);
        single_req = 1'b0;
    endtask

    task automatic wait_quiet(input int max_clks, input string name);
        int n;
        n = 0;
        while (!(exp_bytes.size() == 0 && exp_gap.size() == 0 && !busy && !uart_tx_busy)) begin
            @(negedge clk);
            n++;
            if (n >= max_clks) begin
                fail_evt(name, "no idle within bound", "idle");
                break;
            end
        end
    endtask

    task automatic wait_starts(input int target, input int max_clks, input string name);
        int n;
        n = 0;
        while (sr_starts < target) begin
            @(negedge clk);
            n++;
            if (n >= max_clks) begin
                fail_evt(name, "no sr_start within bound", "sr_start");
                break;
            end
        end
    endtask

    task automatic wait_us(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick_1us) k++;
        end
    endtask

    initial begin
        int base_s;
        int base_u;
        int n;

        // Timeout after reset, stray sr_done ignored, then first good sample 50.
        do_reset();
        stray_cnt++;
        repeat (10) @(negedge clk);
        chk("stray_done_avg_valid", avg_valid, 0);
        chk("stray_done_busy", busy, 0);
        exp_gap.push_back(-1);
        sens_delay.push_back(-1); sens_dist.push_back(0);
        pulse_req();
        n = 0;
        while (!timeout_err && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_at_us", us_time - last_start_us, TMO);
        chk("timeout_idle", busy, 0);
        exp_gap.push_back(CYC);
        sens_delay.push_back(20); sens_dist.push_back(50);
        push_msg(50, "050");
        pulse_req();
        wait_quiet(6000, "sample50_done");
        chk("timeout_err_after_good", timeout_err, 0);

        // Single shot with a slow UART: 1000 clks of busy per byte.
        do_reset();
        uart_busy_len = 1000;
        base_s = sr_starts;
        base_u = uart_starts;
        exp_gap.push_back(-1);
        sens_delay.push_back(71); sens_dist.push_back(123);
        push_msg(123, "123");
        pulse_req();
        wait_quiet(20000, "single_done");
        chk("single_uart_starts", uart_starts - base_u, 5);
        chk("single_sr_starts", sr_starts - base_s, 1);
        chk("single_avg", avg_distance, 123);
        chk("single_idle", busy, 0);

        // Holdoff: second request 100 us after the first start, while busy.
        uart_busy_len = 10;
        base_s = sr_starts;
        exp_gap.push_back(-1);
        sens_delay.push_back(150); sens_dist.push_back(127);
        push_msg(124, "124");
        pulse_req();
        wait_starts(base_s + 1, 5000, "holdoff_first_start");
        wait_us(100);
        chk("busy_at_second_req", busy, 1);
        exp_gap.push_back(CYC);
        sens_delay.push_back(30); sens_dist.push_back(131);
        push_msg(126, "126");
        pulse_req();
        wait_quiet(10000, "holdoff_done");

        // Auto mode: 100,100,100,200, then mode_auto drops mid-measurement.
        do_reset();
        base_s = sr_starts;
        exp_gap.push_back(-1);
        for (int i = 0; i < 3; i++) begin
            exp_gap.push_back(CYC);
            sens_delay.push_back(50); sens_dist.push_back(100);
            push_msg(100, "100");
        end
        sens_delay.push_back(50); sens_dist.push_back(200);
        push_msg(125, "125");
        @(negedge clk);
        mode_auto = 1'b1;
        wait_starts(base_s + 4, 4 * CYC * 4 + 2000, "auto_starts");
        @(negedge clk);
        mode_auto = 1'b0;
        wait_quiet(4000, "auto_done");
        repeat (CYC * 4 * 2) @(negedge clk);
        chk("auto_stop_starts", sr_starts - base_s, 4);
        chk("auto_last_avg", avg_distance, 125);

        // Reset during byte index 2: nothing more is sent afterwards.
        do_reset();
        uart_busy_len = 40;
        base_s = sr_starts;
        base_u = uart_starts;
        exp_gap.push_back(-1);
        sens_delay.push_back(10); sens_dist.push_back(77);
        exp_avg.push_back(77);
        exp_bytes.push_back(8'h30);
        exp_bytes.push_back(8'h37);
        exp_bytes.push_back(8'h37);
        pulse_req();
        n = 0;
        while (uart_starts < base_u + 3 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        do_reset();
        repeat (2000) @(negedge clk);
        chk("post_reset_uart_starts", uart_starts - base_u, 3);
        chk("post_reset_sr_starts", sr_starts - base_s, 1);
        chk("post_reset_idle", busy, 0);

        chk("leftover_bytes", exp_bytes.size(), 0);
        chk("leftover_avg", exp_avg.size(), 0);
        chk("leftover_starts", exp_gap.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sr04_measure_scheduler.md
Name: sr04_measure_scheduler

Overview:
- Sequencer placed in front of the SR04 ultrasonic control unit.
- Issues start pulses to the sensor, either single-shot or periodic, and enforces the minimum re-trigger interval.
- Detects lost measurements by timeout and keeps a 4-sample moving average of distance.
- Streams each averaged result to the UART transmitter as ASCII "DDD\r\n" using a busy handshake.

Parameters:
CYCLE_US, 60000, minimum µs from one sr_start to the next (auto period and single-shot holdoff)
TIMEOUT_US, 30000, µs after sr_start with no sr_done before the measurement is declared lost
AVG_DEPTH_LOG2, 2, log2 of moving-average depth (fixed 4 samples)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_1us  in  1  one-clk pulse every 1 µs
mode_auto  in  1  1 = periodic measurement, 0 = single-shot
single_req  in  1  debounced one-clk request for one measurement
sr_start  out  1  one-clk start pulse to the SR04 control unit
sr_done  in  1  one-clk result-valid pulse from the SR04 control unit
sr_distance  in  9  distance in cm from the SR04 unit, valid when sr_done=1
uart_tx_busy  in  1  UART transmitter busy
uart_tx_start  out  1  one-clk byte-send pulse
uart_tx_data  out  8  byte to send, held stable from the start pulse until the byte completes
avg_distance  out  9  current averaged distance in cm
avg_valid  out  1  1 once at least one good sample has been taken
timeout_err  out  1  sticky: last measurement was lost
busy  out  1  1 in every state except IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all outputs 0; sample buffer, µs counters and pending flag cleared. Reset during a measurement or transmission aborts it immediately; no partial byte is re-sent afterwards.
- period_cnt (16 bit) counts tick_1us from each sr_start and saturates at CYCLE_US. After reset it is preset to CYCLE_US, so the first trigger is allowed immediately.
- pending flag:
  - set by single_req in any state;
  - set continuously while mode_auto=1;
  - cleared when sr_start is issued.
- States:
  - IDLE: if pending and period_cnt>=CYCLE_US, go to TRIG.
  - TRIG: sr_start=1 for exactly one clk; clear period_cnt and to_cnt; go to WAIT_DONE.
  - WAIT_DONE: to_cnt counts tick_1us.
    - sr_done=1: latch sr_distance, go to UPDATE.
    - to_cnt==TIMEOUT_US with no sr_done: set timeout_err=1, go to IDLE (nothing sent).
    - sr_done and timeout in the same clk: sr_done wins.
  - UPDATE (1 clk):
    - Shift the sample into the 4-entry buffer.
    - First good sample after reset preloads all 4 entries.
    - sum is 11 bits; avg_distance = sum>>2, truncating.
    - Set avg_valid=1, clear timeout_err; go to SEND with byte index 0.
  - SEND: wait for uart_tx_busy=0, then drive uart_tx_data and pulse uart_tx_start for 1 clk. Byte order: hundreds, tens, ones (ASCII '0'+digit), 0x0D, 0x0A. Go to ACK.
  - ACK: wait for uart_tx_busy=1, then go to DONE_WAIT.
  - DONE_WAIT: wait for uart_tx_busy=0. If index<4, increment index and go to SEND; otherwise go to IDLE.
- avg_distance updates only in UPDATE; it is stable during transmission.
- Values above 400 (max 511) are transmitted as-is; no clamp.
- mode_auto falling mid-sequence: the current measurement and its transmission complete, then the block stays in IDLE.
- single_req while busy: latched in pending and served after the holdoff.
- sr_done outside WAIT_DONE: ignored.
- Digit conversion is combinational from avg_distance: /100, (/10)%10, %10.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package sr04_pkg holds:
  - state enum;
  - ASCII constants ASCII_0=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - SR04_DIST_W=9;
  - default values for CYCLE_US and TIMEOUT_US.
- One sub-module, sr04_bin2ascii: 9-bit binary in, three 8-bit ASCII digits out (combinational). The FSM, counters and averager stay in the top module.

Test Plan:
- Single shot: mode_auto=0, single_req pulse, sensor model returns sr_done with 123 after 7134 µs -> one sr_start; avg_distance=123; UART bytes 0x31,0x32,0x33,0x0D,0x0A; then IDLE with busy=0.
- Auto mode: mode_auto=1, sensor returns 100,100,100,200 -> sr_start spaced exactly 60000 µs apart; avg_distance sequence 100,100,100,125; "125\r\n" sent last.
- Timeout: single_req with no sr_done -> timeout_err=1 at 30000 µs, no UART bytes, IDLE. Next good sample of 50 -> timeout_err=0, "050\r\n" sent.
- Holdoff: a second single_req 10000 µs after the first sr_start -> second sr_start occurs at exactly 60000 µs after the first.
- UART handshake: uart_tx_busy held high 1000 clks per byte -> each uart_tx_start occurs only after busy=0; uart_tx_data stable while busy; exactly 5 start pulses.
- Reset mid-transmission: rst_n low during byte 2 -> all outputs 0 within the same clk; after release no bytes are sent until a new request.
